// File: rtl/trap_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, cause codes,
// mstatus field positions, FSM state encoding and mstatus update helpers.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL_INSTR  = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ECALL_M        = 4'd11;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MTVAL,
    S_W_MSTATUS,
    S_REDIRECT
  } state_e;

  typedef enum logic [1:0] {
    K_EXC,
    K_XRET,
    K_IRQ
  } kind_e;

  function automatic logic [31:0] mstatus_trap_entry(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE] = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_mret(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE] = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder for enabled machine interrupts: MEI > MSI > MTI.
module irq_prio_enc
  import trap_pkg::*;
(
  input  logic [2:0] irq,
  output logic       valid,
  output logic [3:0] cause
);

  // irq bit order is {MEI, MTI, MSI}, but MSI outranks MTI
  always_comb begin
    valid = |irq;
    cause = 4'd0;
    if (irq[2])      cause = IRQ_MEI;
    else if (irq[0]) cause = IRQ_MSI;
    else if (irq[1]) cause = IRQ_MTI;
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap-entry / MRET controller: drains the pipeline, writes the machine trap
// CSRs one per cycle, then redirects fetch to the handler or back to mepc.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter bit          VECTORED_EN = 1'b1,
  parameter int unsigned DRAIN_MAX   = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_req_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [31:0] exc_tval_i,
  input  logic [31:0] exc_pc_i,
  input  logic        is_xret_i,
  input  logic        wb_valid_i,
  input  logic [31:0] next_pc_i,
  input  logic [2:0]  irq_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mtvec_i,
  input  logic        mem_busy_i,
  output logic        flush_o,
  output logic        stall_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_target_o,
  output logic        busy_o
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MAX - 1);

  state_e      state, next_state;
  kind_e       kind_q, accept_kind;
  logic        accept;
  logic [3:0]  cause_q, drain_cnt;
  logic [31:0] tval_q, epc_q;
  logic        irq_valid;
  logic [3:0]  irq_cause;
  logic        drain_done;

  logic        flush_d, stall_d, we_d, redir_d, busy_d;
  logic [11:0] waddr_d;
  logic [31:0] wdata_d, target_d, vec_base;

  irq_prio_enc u_irq_prio_enc (
    .irq   (irq_i),
    .valid (irq_valid),
    .cause (irq_cause)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= next_state;
  end

  assign drain_done = !mem_busy_i || (drain_cnt == DRAIN_LAST);

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    accept_kind = K_EXC;
    case (state)
      S_IDLE: begin
        if (exc_req_i) begin
          accept = 1'b1;
          accept_kind = K_EXC;
        end else if (is_xret_i) begin
          accept = 1'b1;
          accept_kind = K_XRET;
        end else if (wb_valid_i && mstatus_i[MSTATUS_MIE] && irq_valid) begin
          accept = 1'b1;
          accept_kind = K_IRQ;
        end
        if (accept) next_state = S_DRAIN;
      end
      S_DRAIN:     if (drain_done) next_state = (kind_q == K_XRET) ? S_W_MSTATUS : S_W_MEPC;
      S_W_MEPC:    next_state = S_W_MCAUSE;
      S_W_MCAUSE:  next_state = S_W_MTVAL;
      S_W_MTVAL:   next_state = S_W_MSTATUS;
      S_W_MSTATUS: next_state = S_REDIRECT;
      S_REDIRECT:  next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // The drain counter only runs while DRAIN is held; any exit clears it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      kind_q    <= K_EXC;
      cause_q   <= 4'd0;
      tval_q    <= 32'd0;
      epc_q     <= 32'd0;
      drain_cnt <= 4'd0;
    end else begin
      if (accept) begin
        kind_q  <= accept_kind;
        cause_q <= (accept_kind == K_EXC) ? exc_cause_i :
                   (accept_kind == K_IRQ) ? irq_cause : 4'd0;
        tval_q  <= (accept_kind == K_EXC) ? exc_tval_i : 32'd0;
        epc_q   <= (accept_kind == K_IRQ) ? next_pc_i : exc_pc_i;
      end
      if (state == S_DRAIN && next_state == S_DRAIN) drain_cnt <= drain_cnt + 4'd1;
      else                                         drain_cnt <= 4'd0;
    end
  end

  assign vec_base = {mtvec_i[31:2], 2'b00};

  // Decoded from next_state so the registered outputs line up with the state
  always_comb begin
    flush_d  = 1'b0;
    stall_d  = 1'b0;
    we_d     = 1'b0;
    waddr_d  = 12'd0;
    wdata_d  = 32'd0;
    redir_d  = 1'b0;
    target_d = 32'd0;
    busy_d   = (next_state != S_IDLE);
    case (next_state)
      S_DRAIN: begin
        flush_d = 1'b1;
        stall_d = 1'b1;
      end
      S_W_MEPC: begin
        stall_d = 1'b1;
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        wdata_d = {epc_q[31:2], 2'b00};
      end
      S_W_MCAUSE: begin
        stall_d = 1'b1;
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        wdata_d = {(kind_q == K_IRQ), 27'd0, cause_q};
      end
      S_W_MTVAL: begin
        stall_d = 1'b1;
        we_d    = 1'b1;
        waddr_d = CSR_MTVAL;
        wdata_d = tval_q;
      end
      S_W_MSTATUS: begin
        stall_d = 1'b1;
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        wdata_d = (kind_q == K_XRET) ? mstatus_mret(mstatus_i) : mstatus_trap_entry(mstatus_i);
      end
      S_REDIRECT: begin
        stall_d = 1'b1;
        redir_d = 1'b1;
        if (kind_q == K_XRET)
          target_d = mepc_i;
        else if (kind_q == K_IRQ && VECTORED_EN && mtvec_i[1:0] == 2'b01)
          target_d = vec_base + {26'd0, cause_q, 2'b00};
        else
          target_d = vec_base;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      flush_o       <= 1'b0;
      stall_o       <= 1'b0;
      csr_we_o      <= 1'b0;
      csr_waddr_o   <= 12'd0;
      csr_wdata_o   <= 32'd0;
      pc_redirect_o <= 1'b0;
      pc_target_o   <= 32'd0;
      busy_o        <= 1'b0;
    end else begin
      flush_o       <= flush_d;
      stall_o       <= stall_d;
      csr_we_o      <= we_d;
      csr_waddr_o   <= waddr_d;
      csr_wdata_o   <= wdata_d;
      pc_redirect_o <= redir_d;
      pc_target_o   <= target_d;
      busy_o        <= busy_d;
    end
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
Multi-cycle trap-entry and trap-return controller sitting beside the write-back stage and its CSR file. It accepts a retiring exception, xRET or pending interrupt and drains the pipeline. It then writes mepc/mcause/mtval/mstatus over a dedicated CSR write port, one per cycle. Finally it redirects fetch to the trap vector or to mepc.

Parameters:
VECTORED_EN, 1, 1 = honour mtvec MODE=1 (vectored) for interrupts; 0 = always direct mode
DRAIN_MAX, 15, max cycles spent in DRAIN waiting for mem_busy_i before proceeding anyway (4-bit counter)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
exc_req_i  in  1  synchronous exception at WB (retiring instruction)
exc_cause_i  in  4  exception code (0,2,3,4,6,11)
exc_tval_i  in  32  mtval value for the exception
exc_pc_i  in  32  PC of the faulting/xRET instruction
is_xret_i  in  1  MRET retiring at WB
wb_valid_i  in  1  valid instruction retiring this cycle
next_pc_i  in  32  PC of the next instruction (interrupt mepc)
irq_i  in  3  {meip&mie.MEIE, mtip&mie.MTIE, msip&mie.MSIE}
mstatus_i  in  32  current mstatus
mepc_i  in  32  current mepc
mtvec_i  in  32  current mtvec
mem_busy_i  in  1  outstanding data-bus transaction
flush_o  out  1  kill all younger pipeline stages
stall_o  out  1  freeze fetch/decode
csr_we_o  out  1  CSR write strobe
csr_waddr_o  out  12  CSR address
csr_wdata_o  out  32  CSR write data
pc_redirect_o  out  1  one-cycle fetch redirect strobe
pc_target_o  out  32  redirect target
busy_o  out  1  sequencer not IDLE

Behaviour:
- Reset (asynchronous, rst_i=0): state IDLE, drain counter 0, capture registers 0, all outputs 0.
- States: IDLE, DRAIN, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, REDIRECT.
- IDLE acceptance priority, evaluated each cycle:
  - exc_req_i first.
  - then is_xret_i.
  - then interrupt, only when wb_valid_i=1 and mstatus_i[3] (MIE)=1 and |irq_i.
- Interrupt cause priority: MEI (11) > MSI (3) > MTI (7). mcause bit31=1 for interrupts.
- On acceptance at cycle T, capture kind (EXC/XRET/IRQ), cause, tval, and epc. epc = exc_pc_i for EXC, next_pc_i for IRQ. tval = 0 for IRQ. Then go to DRAIN.
- Inputs are ignored while not IDLE. An interrupt seen together with an exception stays pending in the source; it is re-evaluated only after return to IDLE.
- DRAIN:
  - flush_o=1, stall_o=1.
  - Exit when mem_busy_i=0 or the counter reaches DRAIN_MAX.
  - Exit goes to W_MEPC for EXC/IRQ, or to W_MSTATUS for XRET.
  - The counter clears on exit.
- W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS: exactly one cycle each, csr_we_o=1, stall_o=1, flush_o=0.
  - Addresses: 0x341, 0x342, 0x343, 0x300.
  - mepc data = {epc[31:2], 2'b00}.
- mstatus data for trap entry: MPIE(bit7) <- MIE(bit3), MIE <- 0, MPP[12:11] <- 2'b11, other bits from mstatus_i.
- mstatus data for MRET: MIE <- MPIE, MPIE <- 1, MPP <- 2'b11.
- REDIRECT: one cycle, pc_redirect_o=1, stall_o=1, then IDLE.
  - XRET target: mepc_i.
  - EXC target: {mtvec_i[31:2], 2'b00}.
  - IRQ target: {mtvec_i[31:2], 2'b00} + 4*cause when VECTORED_EN=1 and mtvec_i[1:0]=2'b01; otherwise the same as EXC.
  - Target arithmetic is 32-bit wrap-around.
- Latency with mem_busy_i=0:
  - EXC/IRQ: pc_redirect_o at T+6.
  - XRET: pc_redirect_o at T+3.
  - Each DRAIN wait cycle adds 1.
- busy_o=1 in every state except IDLE. Outputs are registered decodes of state; csr_waddr_o/wdata_o/pc_target_o are 0 when their strobe is low.
- Reset mid-sequence aborts immediately to IDLE with no further CSR writes.

Decomposition:
- Shared package (trap_pkg):
  - CSR address constants MSTATUS/MEPC/MCAUSE/MTVAL.
  - mcause codes (exception and interrupt).
  - mstatus bit-position constants.
  - State enum.
- One natural sub-module: irq_prio_enc (3-bit irq_i to {valid, cause[3:0]}).

Test Plan:
- Illegal instruction: exc_req_i=1, cause=2, tval=0x00000013, pc=0x100, mtvec=0x200, mstatus=0x8 -> four CSR writes at T+2..T+5:
  - 0x341=0x100
  - 0x342=0x2
  - 0x343=0x13
  - 0x300=0x1880
  - then redirect to 0x200 at T+6.
- MRET: mepc_i=0x104, mstatus=0x1880 -> DRAIN, write 0x300=0x1888, redirect to 0x104 at T+3.
- Vectored MTI: irq_i=3'b010, wb_valid_i=1, MIE=1, mtvec=0x201, next_pc=0x40 -> mepc=0x40, mcause=0x80000007, mtval=0, target 0x21C.
- Interrupt gating:
  - MIE=0 with irq_i=3'b111 -> no acceptance, busy_o stays 0.
  - Set MIE=1 -> MEI accepted, mcause=0x8000000B.
- Drain timeout and simultaneous requests:
  - mem_busy_i held high -> DRAIN lasts exactly DRAIN_MAX cycles, then proceeds.
  - exc_req_i and irq together -> exception sequence runs first.
- Async reset asserted during W_MCAUSE -> all outputs 0 immediately, state IDLE, no W_MTVAL write afterwards.
